// File: rtl/tdm_mux_scanner_if.sv
// rtl/tdm_mux_scanner_if.sv - control, data and result bundle for the TDM mux scanner
interface tdm_mux_scanner_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
);
  logic                      en;
  logic                      mode;
  logic [SELW-1:0]           sel_in;
  logic [CHANNELS-1:0]       ch_mask;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [WIDTH-1:0]          out;
  logic [SELW-1:0]           sel_out;
  logic                      out_valid;
  logic                      wrap;

  modport master (
    output en, mode, sel_in, ch_mask, din,
    input  out, sel_out, out_valid, wrap
  );

  modport slave (
    input  en, mode, sel_in, ch_mask, din,
    output out, sel_out, out_valid, wrap
  );
endinterface

// File: rtl/tdm_mux_scanner.sv
// rtl/tdm_mux_scanner.sv - registered N:1 mux with masked auto scan and manual select
module tdm_mux_scanner #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input logic              clk,
  input logic              rst,
  tdm_mux_scanner_if.slave bus
);
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [DCW-1:0]   dwell_q, dwell_d;

  logic [WIDTH-1:0] ch_data [CHANNELS];
  logic [SELW-1:0]  nxt;
  logic             found;
  logic             sel_ok;
  logic             advance;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ch_data[i] = bus.din[i*WIDTH +: WIDTH];
    end
  end

  // Circular search from ptr+1; a lone enabled channel finds itself on the last step.
  always_comb begin
    nxt   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!found && bus.ch_mask[(int'(ptr_q) + k) % CHANNELS]) begin
        nxt   = SELW'((int'(ptr_q) + k) % CHANNELS);
        found = 1'b1;
      end
    end
  end

  assign sel_ok  = (int'(bus.sel_in) < CHANNELS);
  assign advance = !bus.ch_mask[ptr_q] || (dwell_q == DWELL_LAST);

  always_comb begin
    out_d   = out_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (bus.en) begin
      if (bus.mode) begin
        dwell_d = '0;
        if (sel_ok) begin
          out_d   = ch_data[bus.sel_in];
          sel_d   = bus.sel_in;
          ptr_d   = bus.sel_in;
          valid_d = 1'b1;
        end
      end else if (|bus.ch_mask) begin
        out_d   = ch_data[ptr_q];
        sel_d   = ptr_q;
        valid_d = bus.ch_mask[ptr_q];
        if (advance) begin
          ptr_d   = nxt;
          dwell_d = '0;
          wrap_d  = (nxt <= ptr_q);
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ptr_q   <= '0;
      dwell_q <= '0;
    end else begin
      out_q   <= out_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.sel_out   = sel_q;
  assign bus.out_valid = valid_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: doc/tdm_mux_scanner.md
Name: tdm_mux_scanner

Overview:
- Parametrised, registered N-channel, WIDTH-bit multiplexer; successor to the fixed 4:1 combinational mux.
- Auto mode: time-division scans the enabled channels, holding each for DWELL cycles and skipping masked channels.
- Manual mode: output follows an externally supplied select.
- Feeds downstream serialisers and monitors with a registered data/select/valid triple and a wrap pulse marking the end of each scan pass.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels (>=2).
- DWELL, 4, cycles spent on each enabled channel in auto mode (>=1).
- SELW, $clog2(CHANNELS), select width. Derived; do not override.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, global enable; 0 freezes all state.
- mode, input, 1, 0 = auto scan, 1 = manual select.
- sel_in, input, SELW, channel select used in manual mode.
- ch_mask, input, CHANNELS, per-channel enable for auto scan; bit i = channel i.
- din, input, CHANNELS*WIDTH, flattened inputs; channel i = din[i*WIDTH +: WIDTH].
- out, output, WIDTH, registered selected data.
- sel_out, output, SELW, channel index that produced the current out.
- out_valid, output, 1, out/sel_out hold valid channel data.
- wrap, output, 1, one-cycle pulse when the auto scan pointer wraps.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst; rst dominates en and mode.
- Reset values: out=0, sel_out=0, out_valid=0, wrap=0, internal ptr=0, dwell_cnt=0.
- Latency is 1 cycle. out, sel_out and out_valid update together at the edge, using din, ch_mask and sel_in sampled at that edge.
- en=0: out, sel_out, ptr and dwell_cnt hold. out_valid<=0, wrap<=0.
- Manual mode (en=1, mode=1):
  - out<=din[sel_in]; sel_out<=sel_in; ptr<=sel_in; dwell_cnt<=0; wrap<=0.
  - out_valid<=1 if sel_in<CHANNELS. Otherwise out_valid<=0 and out, sel_out and ptr hold.
  - ch_mask is ignored in manual mode.
- Auto mode (en=1, mode=0):
  - ch_mask==0: out, sel_out, ptr and dwell_cnt hold; out_valid<=0; wrap<=0.
  - Otherwise: out<=din[ptr]; sel_out<=ptr; out_valid<=ch_mask[ptr].
  - Advance condition: ch_mask[ptr]==0, or dwell_cnt==DWELL-1.
  - On advance: ptr<=nxt, where nxt is the first index with its mask bit set, searching circularly from ptr+1 (index CHANNELS-1 wraps to 0). dwell_cnt<=0.
  - If no advance: dwell_cnt<=dwell_cnt+1.
  - wrap<=1 exactly on an advance where nxt<=ptr. This includes a single enabled channel advancing onto itself.
  - A masked ptr produces exactly one out_valid=0 cycle before moving on.
- Mode switch manual->auto: the scan resumes at the current ptr with dwell_cnt=0.
- Mode switch auto->manual: takes effect on the next edge.
- ch_mask changes take effect on the next edge. A channel masked mid-dwell is abandoned immediately under the advance rule.
- No combinational path from inputs to outputs.

Test Plan:
Common setup: WIDTH=8, CHANNELS=4, DWELL=2; din ch0..ch3 = AA, BB, CC, DD.
- Reset check: assert rst for 3 cycles with en=1 and random inputs -> out=00, sel_out=0, out_valid=0, wrap=0 every cycle; first auto cycle after release gives out=AA, sel_out=0.
- Auto full scan, ch_mask=1111, mode=0, en=1:
  - out sequence AA,AA,BB,BB,CC,CC,DD,DD,AA.
  - out_valid=1 throughout.
  - wrap=1 only in the cycle when ch3's second output is presented.
- Auto with skip, ch_mask=0101 (ch0 and ch2 enabled):
  - out sequence AA,AA,CC,CC,AA.
  - ch1 and ch3 never appear.
  - wrap pulses once per pass.
  - ch_mask=0000 -> out_valid=0 and out/sel_out frozen.
- Manual mode: mode=1, sel_in=2,3,1 on consecutive cycles -> one cycle later out=CC,DD,BB with sel_out=2,3,1 and out_valid=1. Then mode=0 -> scan continues BB,BB,CC.
- Freeze: en=0 for 5 cycles mid-dwell on ch1 -> out=BB held, out_valid=0. Restore en=1 -> exactly one more BB, then CC.
- Synchronous reset mid-scan: rst asserted while sel_out=3 -> all outputs return to reset values on the next edge; the scan restarts from ch0 with a full DWELL.
